dram_cmd_sched: RTL and testbench
=================================

# dram_cmd_sched

Parametrised DRAM command scheduler: the next generation of the controller FSM, sitting between the request front-end and the DRAM command bus. It tracks one open row per bank and issues ACT/RD/WR/PRE/PREA/REF with enforced tRCD/tRP/tRFC waits. It supports page-hit bypass, open-page or close-page policy, configurable burst length with column wrap, and refresh insertion between bursts.

## Interface
- NUMBER_OF_BANKS, 8, banks (power of 2, ≥2)
- NUMBER_OF_ROWS, 128, rows per bank (power of 2)
- NUMBER_OF_COLS, 8, columns per row (power of 2)
- BURST_LEN, 4, column commands per request (power of 2, ≤ NUMBER_OF_COLS)
- T_RCD, 2, cycles from ACT accepted to first column command (≥1)
- T_RP, 2, cycles from PRE/PREA accepted to next ACT/REF (≥1)
- T_RFC, 4, cycles from REF accepted to refresh_ack (≥1)
- OPEN_PAGE, 1, 1 = leave row open after burst, 0 = auto-precharge after burst
- clk  in  1  clock, rising edge
- rst_b  in  1  asynchronous active-low reset
- req_val  in  1  request valid
- req_rdy  out  1  scheduler can accept a request
- req_wr  in  1  1 = write burst, 0 = read burst
- req_bank  in  clog2(NUMBER_OF_BANKS)  target bank
- req_row  in  clog2(NUMBER_OF_ROWS)  target row
- req_col  in  clog2(NUMBER_OF_COLS)  starting column
- refresh_flag  in  1  level refresh request from refresh timer
- refresh_ack  out  1  one-cycle pulse, refresh complete
- cmd_val  out  1  command valid
- cmd_ack  in  1  command accepted by PHY
- cmd  out  3  NOP=000 ACT=001 RD=010 WR=011 PRE=100 PREA=101 REF=110
- cmd_bank / cmd_row / cmd_col  out  bank/row/col widths  command address
- done  out  1  one-cycle pulse, last column command of burst accepted

## Operation
- States: IDLE, ACT, RCD_WAIT, COL, PRE, RP_WAIT, REF_PREA, REF_RP, REF, RFC_WAIT.
- Open-row table: per bank a valid bit and row; cleared by reset and by REF completion.
- IDLE: refresh_flag has priority over req_val. refresh_flag=1 → REF_PREA if any bank is open, else REF. Otherwise req_val & req_rdy latches wr/bank/row/col.
- Request dispatch: bank open with same row → COL (page hit); bank open with another row → PRE; bank closed → ACT.
- PRE → RP_WAIT → ACT; table valid[bank] cleared on PRE accept. ACT accept sets valid[bank] and row[bank], then RCD_WAIT → COL.
- COL issues BURST_LEN RD/WR commands. Column = aligned burst base | ((start + n) mod BURST_LEN), so the burst wraps inside its aligned block.
- After the last column accept: done pulses. If OPEN_PAGE=1 → IDLE. If OPEN_PAGE=0 → PRE (row closed) → RP_WAIT → IDLE.
- Refresh path: PREA (cmd_bank=0) → REF_RP waits T_RP → REF → RFC_WAIT waits T_RFC → refresh_ack pulse, table cleared, IDLE.
- Refresh is never inserted mid-burst; refresh_flag during a burst is serviced on the next IDLE visit.
- Unused address fields are driven 0.

## Timing
- Handshake: cmd_val held with cmd and address stable until cmd_ack. Transfer occurs on cmd_val & cmd_ack. cmd_ack with cmd_val=0 is ignored. cmd=NOP whenever cmd_val=0.
- req_rdy = (state==IDLE) & !refresh_flag, combinational.
- Latencies, with request accepted at cycle N:
  - Page hit: first RD/WR cmd_val at N+1.
  - Closed bank: ACT at N+1.
  - Conflict: PRE at N+1.
- Wait rules, with accept at cycle A:
  - ACT accepted at A → first column cmd_val at A+T_RCD.
  - PRE/PREA accepted at A → next ACT/REF cmd_val at A+T_RP.
  - REF accepted at A → refresh_ack at A+T_RFC, req_rdy may rise at A+T_RFC+1.
- With cmd_ack tied high, consecutive column commands issue one per cycle.
- Reset (asynchronous, any state): state=IDLE, table cleared, counters 0. cmd_val=0, cmd=NOP, addresses 0, done=0, refresh_ack=0. req_rdy=!refresh_flag.
- Reset mid-burst drops the burst; no done is produced.

## Test plan
- Reset, then read bank 2 row 5 col 1, cmd_ack=1, T_RCD=2 → ACT(2,5) at N+1, RD cols 1,2,3,0 from N+3, done with the 4th RD, bank 2 marked open.
- Second read bank 2 row 5 col 4 → RD at N+1 with no ACT (page hit), cols 4,5,6,7.
- Read bank 2 row 9 → PRE(2) at N+1, ACT(2,9) T_RP cycles after PRE accept, then RD burst.
- refresh_flag=1 in IDLE with banks open → PREA, REF T_RP later, refresh_ack T_RFC after REF accept, next request to bank 2 issues ACT (table cleared).
- cmd_ack held low 3 cycles on an ACT → cmd_val/cmd/address stable for all 3 cycles; T_RCD counted from accept cycle.
- OPEN_PAGE=0, write burst → WR×BURST_LEN, done, PRE, IDLE T_RP cycles later; rst_b=0 mid-burst → cmd_val=0 immediately, no done.

Source files
------------

// File: rtl/dram_cmd_sched.sv
// DRAM command scheduler: per-bank open-row tracking, ACT/RD/WR/PRE/PREA/REF
// sequencing with tRCD/tRP/tRFC waits, open- or close-page policy and wrapped bursts.
module dram_cmd_sched #(
  parameter int NUMBER_OF_BANKS = 8,
  parameter int NUMBER_OF_ROWS  = 128,
  parameter int NUMBER_OF_COLS  = 8,
  parameter int BURST_LEN       = 4,
  parameter int T_RCD           = 2,
  parameter int T_RP            = 2,
  parameter int T_RFC           = 4,
  parameter bit OPEN_PAGE       = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst_b,
  input  logic                               req_val,
  output logic                               req_rdy,
  input  logic                               req_wr,
  input  logic [$clog2(NUMBER_OF_BANKS)-1:0] req_bank,
  input  logic [$clog2(NUMBER_OF_ROWS)-1:0]  req_row,
  input  logic [$clog2(NUMBER_OF_COLS)-1:0]  req_col,
  input  logic                               refresh_flag,
  output logic                               refresh_ack,
  output logic                               cmd_val,
  input  logic                               cmd_ack,
  output logic [2:0]                         cmd,
  output logic [$clog2(NUMBER_OF_BANKS)-1:0] cmd_bank,
  output logic [$clog2(NUMBER_OF_ROWS)-1:0]  cmd_row,
  output logic [$clog2(NUMBER_OF_COLS)-1:0]  cmd_col,
  output logic                               done
);

  localparam int BANK_W = $clog2(NUMBER_OF_BANKS);
  localparam int ROW_W  = $clog2(NUMBER_OF_ROWS);
  localparam int COL_W  = $clog2(NUMBER_OF_COLS);
  localparam int MAX_A  = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int MAX_B  = (MAX_A > T_RFC) ? MAX_A : T_RFC;
  localparam int MAX_T  = (MAX_B > BURST_LEN) ? MAX_B : BURST_LEN;
  localparam int CNT_W  = $clog2(MAX_T + 1);
  localparam logic [COL_W-1:0] BL_MASK = COL_W'(BURST_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ACT, S_RCD_WAIT, S_COL, S_PRE, S_RP_WAIT,
    S_REF_PREA, S_REF_RP, S_REF, S_RFC_WAIT
  } state_t;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'b000, CMD_ACT = 3'b001, CMD_RD  = 3'b010, CMD_WR = 3'b011,
    CMD_PRE  = 3'b100, CMD_PREA = 3'b101, CMD_REF = 3'b110
  } cmd_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               lat_wr, closing;
  logic [BANK_W-1:0]  lat_bank;
  logic [ROW_W-1:0]   lat_row;
  logic [COL_W-1:0]   lat_col, col_sum;
  logic [NUMBER_OF_BANKS-1:0] open_valid;
  logic [ROW_W-1:0]   open_row [NUMBER_OF_BANKS];
  logic               accept, hit, act_xfer, pre_xfer;

  assign hit      = open_valid[req_bank] && (open_row[req_bank] == req_row);
  assign act_xfer = (state == S_ACT) && cmd_ack;
  assign pre_xfer = (state == S_PRE) && cmd_ack;
  assign col_sum  = lat_col + COL_W'(cnt);

  // NOTE: every output is given a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    req_rdy     = 1'b0;
    accept      = 1'b0;
    cmd_val     = 1'b0;
    cmd         = CMD_NOP;
    cmd_bank    = '0;
    cmd_row     = '0;
    cmd_col     = '0;
    done        = 1'b0;
    refresh_ack = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_rdy = !refresh_flag;
        cnt_d   = '0;
        if (refresh_flag) begin
          state_d = (|open_valid) ? S_REF_PREA : S_REF;
        end else if (req_val) begin
          accept  = 1'b1;
          state_d = hit ? S_COL : (open_valid[req_bank] ? S_PRE : S_ACT);
        end
      end
      S_ACT: begin
        cmd_val  = 1'b1;
        cmd      = CMD_ACT;
        cmd_bank = lat_bank;
        cmd_row  = lat_row;
        if (cmd_ack) state_d = (T_RCD == 1) ? S_COL : S_RCD_WAIT;
      end
      // Wait states last T-1 cycles so the next command appears T cycles after the accept.
      S_RCD_WAIT: begin
        if (cnt == CNT_W'(T_RCD - 2)) begin
          state_d = S_COL;
          cnt_d   = '0;
        end else cnt_d = cnt + CNT_W'(1);
      end
      S_COL: begin
        cmd_val  = 1'b1;
        cmd      = lat_wr ? CMD_WR : CMD_RD;
        cmd_bank = lat_bank;
        cmd_col  = (lat_col & ~BL_MASK) | (col_sum & BL_MASK);
        if (cmd_ack) begin
          if (cnt == CNT_W'(BURST_LEN - 1)) begin
            done    = 1'b1;
            cnt_d   = '0;
            state_d = OPEN_PAGE ? S_IDLE : S_PRE;
          end else cnt_d = cnt + CNT_W'(1);
        end
      end
      S_PRE: begin
        cmd_val  = 1'b1;
        cmd      = CMD_PRE;
        cmd_bank = lat_bank;
        if (cmd_ack) begin
          cnt_d   = '0;
          state_d = (T_RP != 1) ? S_RP_WAIT : (closing ? S_IDLE : S_ACT);
        end
      end
      S_RP_WAIT: begin
        if (cnt == CNT_W'(T_RP - 2)) begin
          state_d = closing ? S_IDLE : S_ACT;
          cnt_d   = '0;
        end else cnt_d = cnt + CNT_W'(1);
      end
      S_REF_PREA: begin
        cmd_val = 1'b1;
        cmd     = CMD_PREA;
        if (cmd_ack) begin
          cnt_d   = '0;
          state_d = (T_RP == 1) ? S_REF : S_REF_RP;
        end
      end
      S_REF_RP: begin
        if (cnt == CNT_W'(T_RP - 2)) begin
          state_d = S_REF;
          cnt_d   = '0;
        end else cnt_d = cnt + CNT_W'(1);
      end
      S_REF: begin
        cmd_val = 1'b1;
        cmd     = CMD_REF;
        if (cmd_ack) begin
          cnt_d   = '0;
          state_d = S_RFC_WAIT;
        end
      end
      S_RFC_WAIT: begin
        if (cnt == CNT_W'(T_RFC - 1)) begin
          refresh_ack = 1'b1;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end else cnt_d = cnt + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      lat_wr     <= 1'b0;
      lat_bank   <= '0;
      lat_row    <= '0;
      lat_col    <= '0;
      closing    <= 1'b0;
      open_valid <= '0;
    end else begin
      if (accept) begin
        lat_wr   <= req_wr;
        lat_bank <= req_bank;
        lat_row  <= req_row;
        lat_col  <= req_col;
        closing  <= 1'b0;
      end
      if (done) closing <= !OPEN_PAGE;
      if (act_xfer) open_valid[lat_bank] <= 1'b1;
      if (pre_xfer) open_valid[lat_bank] <= 1'b0;
      if (refresh_ack) open_valid <= '0;
    end
  end

  // NOTE: row storage is not reset; an entry is only read while its valid bit, which is reset, is set.
  always_ff @(posedge clk) begin
    if (act_xfer) open_row[lat_bank] <= lat_row;
  end

endmodule

// File: tb/tb_dram_cmd_sched.sv
// Randomized self-checking bench for dram_cmd_sched: an open-page and a close-page
// instance share stimulus, one active at a time, checked against a transaction model.
module tb_dram_cmd_sched;

  localparam int NB = 8, NR = 128, NC = 8, BL = 4;
  localparam int T_RCD = 2, T_RP = 2, T_RFC = 4;
  localparam logic [2:0] OP_NOP = 3'b000, OP_ACT = 3'b001, OP_RD = 3'b010, OP_WR = 3'b011;
  localparam logic [2:0] OP_PRE = 3'b100, OP_PREA = 3'b101, OP_REF = 3'b110;

  typedef struct {
    logic [2:0] op;
    int         bank;
    int         row;
    int         col;
    bit         last;
  } exp_cmd_t;

  logic       clk = 1'b0, rst_b, sel;
  logic       req_val, req_wr, refresh_flag, cmd_ack;
  logic [2:0] req_bank, req_col;
  logic [6:0] req_row;

  logic       a_req_rdy, a_refresh_ack, a_cmd_val, a_done;
  logic [2:0] a_cmd, a_cmd_bank, a_cmd_col;
  logic [6:0] a_cmd_row;
  logic       b_req_rdy, b_refresh_ack, b_cmd_val, b_done;
  logic [2:0] b_cmd, b_cmd_bank, b_cmd_col;
  logic [6:0] b_cmd_row;

  logic       req_rdy, refresh_ack, cmd_val, done;
  logic [2:0] cmd, cmd_bank, cmd_col;
  logic [6:0] cmd_row;

  assign req_rdy     = sel ? b_req_rdy     : a_req_rdy;
  assign refresh_ack = sel ? b_refresh_ack : a_refresh_ack;
  assign cmd_val     = sel ? b_cmd_val     : a_cmd_val;
  assign done        = sel ? b_done        : a_done;
  assign cmd         = sel ? b_cmd         : a_cmd;
  assign cmd_bank    = sel ? b_cmd_bank    : a_cmd_bank;
  assign cmd_row     = sel ? b_cmd_row     : a_cmd_row;
  assign cmd_col     = sel ? b_cmd_col     : a_cmd_col;

  dram_cmd_sched #(.NUMBER_OF_BANKS(NB), .NUMBER_OF_ROWS(NR), .NUMBER_OF_COLS(NC),
    .BURST_LEN(BL), .T_RCD(T_RCD), .T_RP(T_RP), .T_RFC(T_RFC), .OPEN_PAGE(1'b1)) dut_open (
    .clk(clk), .rst_b(rst_b), .req_val(req_val & ~sel), .req_rdy(a_req_rdy), .req_wr(req_wr),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .refresh_flag(refresh_flag & ~sel), .refresh_ack(a_refresh_ack), .cmd_val(a_cmd_val),
    .cmd_ack(cmd_ack), .cmd(a_cmd), .cmd_bank(a_cmd_bank), .cmd_row(a_cmd_row),
    .cmd_col(a_cmd_col), .done(a_done));

  dram_cmd_sched #(.NUMBER_OF_BANKS(NB), .NUMBER_OF_ROWS(NR), .NUMBER_OF_COLS(NC),
    .BURST_LEN(BL), .T_RCD(T_RCD), .T_RP(T_RP), .T_RFC(T_RFC), .OPEN_PAGE(1'b0)) dut_close (
    .clk(clk), .rst_b(rst_b), .req_val(req_val & sel), .req_rdy(b_req_rdy), .req_wr(req_wr),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .refresh_flag(refresh_flag & sel), .refresh_ack(b_refresh_ack), .cmd_val(b_cmd_val),
    .cmd_ack(cmd_ack), .cmd(b_cmd), .cmd_bank(b_cmd_bank), .cmd_row(b_cmd_row),
    .cmd_col(b_cmd_col), .done(b_done));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int       n_chk = 0, n_err = 0;
  bit       mv [NB];
  int       mr [NB];
  exp_cmd_t exp_q[$];
  int       hold_act   = -1;
  bit       ack_random = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NB; i++) mv[i] = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_val"}, cmd_val, 0);
    check({tag, "_cmd"}, cmd, OP_NOP);
    check({tag, "_addr"}, {cmd_bank, cmd_row, cmd_col}, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_refresh_ack"}, refresh_ack, 0);
    check({tag, "_req_rdy"}, req_rdy, 1);
    refresh_flag = 1'b1;
    #1 check({tag, "_req_rdy_refresh"}, req_rdy, 0);
    refresh_flag = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    #2 check_idle_outputs("reset");
    @(negedge clk);
    rst_b = 1'b1;
    clear_model();
    tick();
    check_idle_outputs("post_reset");
  endtask

  task automatic check_cmd(input exp_cmd_t e);
    check("cmd_val", cmd_val, 1);
    check("cmd", cmd, e.op);
    check("cmd_bank", cmd_bank, e.bank);
    check("cmd_row", cmd_row, e.row);
    check("cmd_col", cmd_col, e.col);
  endtask

  // Walks exp_q: checks each command's first appearance against the wait rules,
  // its stability while cmd_ack is withheld, and done on the accepting cycle.
  task automatic run_cmds(input int start, input int limit, output int last_acc, output bit ok);
    int         prev = start;
    logic [2:0] prev_op = OP_NOP;
    ok = 1'b1;
    last_acc = start;
    for (int i = 0; i < exp_q.size() && i < limit; i++) begin
      exp_cmd_t e;
      int gap, hold, guard;
      e     = exp_q[i];
      gap   = (prev_op == OP_ACT) ? T_RCD : ((prev_op == OP_PRE || prev_op == OP_PREA) ? T_RP : 1);
      guard = 0;
      while (cmd_val !== 1'b1 && guard < 64) begin
        tick();
        guard++;
      end
      if (cmd_val !== 1'b1) begin
        check("cmd_val_timeout", 0, 1);
        ok = 1'b0;
        return;
      end
      check("cmd_latency", cyc - prev, gap);
      if (e.op == OP_ACT && hold_act >= 0) hold = hold_act;
      else if (ack_random && $urandom_range(0, 2) == 0) hold = $urandom_range(1, 3);
      else hold = 0;
      for (int h = 0; h < hold; h++) begin
        check_cmd(e);
        cmd_ack = 1'b0;
        tick();
      end
      check_cmd(e);
      cmd_ack = 1'b1;
      #1 check("done", done, e.last);
      prev = cyc;
      last_acc = cyc;
      prev_op = e.op;
      tick();
      cmd_ack = 1'b0;
    end
  endtask

  task automatic issue_req(input bit wr, input int b, input int r, input int c, input int limit);
    int  guard, n, last, base;
    bit  ok;
    bit  open_page;
    exp_cmd_t e;
    open_page = !sel;
    guard = 0;
    while (!req_rdy && guard < 64) begin
      tick();
      guard++;
    end
    check("req_rdy_before_req", req_rdy, 1);
    if (!req_rdy) return;
    req_val = 1'b1; req_wr = wr; req_bank = 3'(b); req_row = 7'(r); req_col = 3'(c);
    n = cyc;
    tick();
    req_val = 1'b0;
    exp_q.delete();
    if (!(mv[b] && mr[b] == r)) begin
      if (mv[b]) begin
        e = '{OP_PRE, b, 0, 0, 1'b0};
        exp_q.push_back(e);
      end
      e = '{OP_ACT, b, r, 0, 1'b0};
      exp_q.push_back(e);
    end
    base = c - (c % BL);
    for (int k = 0; k < BL; k++) begin
      e = '{wr ? OP_WR : OP_RD, b, 0, base + ((c + k) % BL), k == BL - 1};
      exp_q.push_back(e);
    end
    if (!open_page) begin
      e = '{OP_PRE, b, 0, 0, 1'b0};
      exp_q.push_back(e);
    end
    run_cmds(n, limit, last, ok);
    if (!ok || limit < exp_q.size()) return;
    mv[b] = open_page;
    mr[b] = r;
    guard = 0;
    while (!req_rdy && guard < 64) begin
      tick();
      guard++;
    end
    check("idle_return_latency", cyc - last, open_page ? 1 : T_RP);
  endtask

  task automatic do_refresh();
    int  s, last, guard;
    bit  ok, any;
    exp_cmd_t e;
    refresh_flag = 1'b1;
    #1 check("req_rdy_during_refresh", req_rdy, 0);
    s = cyc;
    any = 1'b0;
    for (int i = 0; i < NB; i++) any |= mv[i];
    exp_q.delete();
    if (any) begin
      e = '{OP_PREA, 0, 0, 0, 1'b0};
      exp_q.push_back(e);
    end
    e = '{OP_REF, 0, 0, 0, 1'b0};
    exp_q.push_back(e);
    run_cmds(s, 99, last, ok);
    refresh_flag = 1'b0;
    if (!ok) return;
    guard = 0;
    while (refresh_ack !== 1'b1 && guard < 64) begin
      tick();
      guard++;
    end
    check("refresh_ack_latency", cyc - last, T_RFC);
    tick();
    check("refresh_ack_pulse", refresh_ack, 0);
    check("req_rdy_after_refresh", req_rdy, 1);
    clear_model();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_b = 1'b0; sel = 1'b0;
    req_val = 1'b0; req_wr = 1'b0; req_bank = '0; req_row = '0; req_col = '0;
    refresh_flag = 1'b0; cmd_ack = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    do_reset();

    // Open-page instance: directed sequence, then random traffic.
    issue_req(1'b0, 2, 5, 1, 99);
    issue_req(1'b0, 2, 5, 4, 99);
    issue_req(1'b0, 2, 9, 0, 99);
    issue_req(1'b1, 6, 3, 7, 99);
    do_refresh();
    issue_req(1'b0, 2, 9, 3, 99);
    hold_act = 3;
    issue_req(1'b1, 5, 7, 6, 99);
    hold_act = -1;
    do_refresh();
    do_refresh();
    ack_random = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 6) == 0) do_refresh();
      else issue_req(1'($urandom_range(0, 1)), $urandom_range(0, NB - 1),
                     $urandom_range(0, 3), $urandom_range(0, NC - 1), 99);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Close-page instance.
    sel = 1'b1;
    ack_random = 1'b0;
    do_reset();
    issue_req(1'b1, 3, 4, 2, 99);
    issue_req(1'b0, 3, 4, 6, 99);
    ack_random = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 5) == 0) do_refresh();
      else issue_req(1'($urandom_range(0, 1)), $urandom_range(0, NB - 1),
                     $urandom_range(0, 3), $urandom_range(0, NC - 1), 99);
    end

    // Reset in the middle of a burst: outputs drop at once and no done appears.
    ack_random = 1'b0;
    do_reset();
    issue_req(1'b0, 6, 11, 5, 2);
    check("midburst_cmd_val_before_reset", cmd_val, 1);
    cmd_ack = 1'b1;
    rst_b = 1'b0;
    #1 check("midburst_cmd_val", cmd_val, 0);
    check("midburst_cmd", cmd, OP_NOP);
    check("midburst_done", done, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("midburst_done_in_reset", done, 0);
      check("midburst_cmd_val_in_reset", cmd_val, 0);
    end
    cmd_ack = 1'b0;
    rst_b = 1'b1;
    clear_model();
    tick();
    check_idle_outputs("after_midburst_reset");
    issue_req(1'b0, 6, 11, 5, 99);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
